rgb_pixel_source: RTL and testbench
===================================

RGB_PIXEL_SOURCE -- requirements
Module: rgb_pixel_source

Interface
REQ-001 Parameter WIDTH, default 2, image width in pixels.
REQ-002 Parameter HEIGHT, default 2, image height in pixels.
REQ-003 Parameter AW, default 16, memory address width.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  single-cycle pulse that begins one frame; ignored unless state is IDLE.
REQ-007 rd_en  out  1  source-memory read strobe.
REQ-008 rd_addr  out  AW  source-memory byte address.
REQ-009 rd_data  in  8  source-memory read data, valid exactly one cycle after rd_en.
REQ-010 dout  out  8  RGB byte presented to the grayscale consumer.
REQ-011 dout_valid  out  1  dout holds a byte not yet accepted.
REQ-012 pause  in  1  consumer stall; byte accepted on an edge where dout_valid=1 and pause=0.
REQ-013 gray_valid  in  1  consumer result strobe, one cycle per pixel.
REQ-014 gray_data  in  8  consumer grayscale result.
REQ-015 wr_en, wr_addr[AW-1:0], wr_data[7:0]  out  destination-memory write port.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  single-cycle pulse when frame completes.

Function
REQ-018 The block SHALL stream 3*WIDTH*HEIGHT bytes from addresses 0..3*WIDTH*HEIGHT-1 in ascending order, R,G,B per pixel.
REQ-019 States SHALL be IDLE, PRIME, STREAM, DRAIN, FIN.
REQ-020 IDLE->PRIME on start; PRIME issues read of address 0 (rd_en=1) and moves to STREAM.
REQ-021 In STREAM, rd_en SHALL equal (dout_valid=0 or pause=0) and reads remain, combinationally.
REQ-022 dout SHALL load rd_data one cycle after each read; dout_valid set on load, cleared on acceptance without concurrent load.
REQ-023 While pause=1 with dout_valid=1, dout, dout_valid and rd_addr SHALL hold, with rd_en=0.
REQ-024 Sustained throughput SHALL be one byte per cycle with pause=0; first byte valid 2 cycles after start.
REQ-025 rd_addr SHALL increment only on cycles with rd_en=1 and SHALL not exceed 3*WIDTH*HEIGHT-1.
REQ-026 Acceptance of the last byte SHALL move STREAM->DRAIN.
REQ-027 In any non-IDLE state, gray_valid=1 SHALL produce wr_en=1, wr_data=gray_data, wr_addr=pixel count, same cycle; pixel count then increments.
REQ-028 gray_valid in IDLE or after WIDTH*HEIGHT results SHALL be ignored (no write).
REQ-029 When pixel count reaches WIDTH*HEIGHT in DRAIN, state SHALL go to FIN; FIN pulses done=1 one cycle, then IDLE.
REQ-030 Pixel count reaching WIDTH*HEIGHT before STREAM ends SHALL not end the frame early.
REQ-031 Byte and pixel counters SHALL be wide enough for 3*WIDTH*HEIGHT without wrap.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, counters 0, rd_addr 0, dout 0, and rd_en, dout_valid, wr_en, busy, done 0.
REQ-033 Reset mid-frame SHALL abandon the frame; next start begins at address 0.

Structure
REQ-034 State encoding and IDLE..FIN constants SHALL reside in shared package img_pkg, reused by the grayscale consumer.
REQ-035 One sub-module, gray_writeback (pixel counter plus write port), SHALL be instantiated; the read/stream FSM stays in the top.

Verification
REQ-036 WIDTH=HEIGHT=2, memory 0x10..0x1B, pause=0 -> dout sequence 0x10..0x1B on consecutive cycles, first at start+2.
REQ-037 pause=1 for 3 cycles while dout=0x12 -> dout stays 0x12, rd_en=0, then 0x13 next cycle after release.
REQ-038 Four gray_valid pulses with 0xA0..0xA3 -> writes to addresses 0..3, done one cycle after fourth write.
REQ-039 start pulsed while busy=1 -> no effect on addresses or counts.
REQ-040 rst_n low after 5 bytes accepted, then start -> stream restarts at address 0, pixel count 0.
REQ-041 gray_valid during IDLE -> wr_en stays 0.

Source files
------------

// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared image-pipeline state encoding and sizing helpers
package img_pkg;

    // Frame sequencing states shared by the pixel source and the grayscale consumer
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRIME  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        FIN    = 3'd4
    } img_state_t;

    localparam int BYTES_PER_PIXEL = 3;

    // Bits needed to hold the values 0..max_count inclusive
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/gray_writeback.sv
// rtl/gray_writeback.sv - pixel counter and destination-memory write port
module gray_writeback
    import img_pkg::*;
#(
    parameter int NPIX = 4,
    parameter int AW   = 16,
    parameter int CW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  img_state_t       state,
    input  logic             start,
    input  logic             gray_valid,
    input  logic [7:0]       gray_data,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [7:0]       wr_data,
    output logic             pix_done
);

    logic [CW-1:0] pix_cnt;
    logic          active;
    logic          frame_start;

    assign active      = (state != IDLE);
    assign frame_start = (state == IDLE) && start;

    // Results beyond the last pixel of the frame are dropped, not written
    assign wr_en   = active && gray_valid && (pix_cnt < CW'(NPIX));
    assign wr_addr = AW'(pix_cnt);
    assign wr_data = gray_data;

    // Looks one write ahead so the frame can close the cycle after the final result
    assign pix_done = (pix_cnt == CW'(NPIX)) || (wr_en && (pix_cnt == CW'(NPIX - 1)));

    // Pixel counter: cleared when a frame begins, advanced on every accepted result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt <= '0;
        end else if (frame_start) begin
            pix_cnt <= '0;
        end else if (wr_en) begin
            pix_cnt <= pix_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rgb_pixel_source.sv
// rtl/rgb_pixel_source.sv - streams RGB bytes from memory and writes back grayscale results
module rgb_pixel_source
    import img_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int HEIGHT = 2,
    parameter int AW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic [7:0]    dout,
    output logic          dout_valid,
    input  logic          pause,
    input  logic          gray_valid,
    input  logic [7:0]    gray_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy,
    output logic          done
);

    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int TOTAL = BYTES_PER_PIXEL * NPIX;
    localparam int CW    = cnt_width(TOTAL);
    localparam logic [AW-1:0] LAST_ADDR = AW'(TOTAL - 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(TOTAL - 1);

    img_state_t    state;
    img_state_t    state_nxt;
    logic          rd_all;
    logic          rd_pend;
    logic [CW-1:0] acc_cnt;
    logic [7:0]    skid;
    logic          skid_valid;
    logic          accept;
    logic          last_accept;
    logic          pix_done;
    logic          frame_start;

    assign accept      = dout_valid && !pause;
    assign last_accept = accept && (acc_cnt == LAST_BYTE);
    assign frame_start = (state == IDLE) && start;
    assign busy        = (state != IDLE);
    assign done        = (state == FIN);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and read-strobe decode
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = PRIME;
                end
            end
            PRIME: begin
                rd_en     = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                rd_en = (!dout_valid || !pause) && !rd_all;
                if (last_accept) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pix_done) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Read side: address advances per strobe and parks on the last byte of the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= '0;
            rd_all  <= 1'b0;
            rd_pend <= 1'b0;
        end else if (frame_start) begin
            rd_addr <= '0;
            rd_all  <= 1'b0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= rd_en;
            if (rd_en) begin
                if (rd_addr == LAST_ADDR) begin
                    rd_all <= 1'b1;
                end else begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end
        end
    end

    // Output side: a read already in flight when the consumer stalls is parked in skid
    // and presented right after the held byte is taken, so no byte is lost or repeated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            skid       <= '0;
            skid_valid <= 1'b0;
            acc_cnt    <= '0;
        end else if (frame_start) begin
            dout_valid <= 1'b0;
            skid_valid <= 1'b0;
            acc_cnt    <= '0;
        end else begin
            if (accept) begin
                acc_cnt <= acc_cnt + 1'b1;
            end
            if (rd_pend) begin
                if (dout_valid && !accept) begin
                    skid       <= rd_data;
                    skid_valid <= 1'b1;
                end else begin
                    dout       <= rd_data;
                    dout_valid <= 1'b1;
                end
            end else if (accept) begin
                if (skid_valid) begin
                    dout       <= skid;
                    skid_valid <= 1'b0;
                end else begin
                    dout_valid <= 1'b0;
                end
            end
        end
    end

    gray_writeback #(
        .NPIX (NPIX),
        .AW   (AW),
        .CW   (CW)
    ) u_gray_writeback (
        .clk        (clk),
        .rst_n      (rst_n),
        .state      (state),
        .start      (start),
        .gray_valid (gray_valid),
        .gray_data  (gray_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pix_done   (pix_done)
    );

endmodule

// File: tb/tb_rgb_pixel_source.sv
// tb/tb_rgb_pixel_source.sv - directed table-driven bench for rgb_pixel_source
module tb_rgb_pixel_source;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        pause;
    logic        gray_valid;
    logic [7:0]  gray_data;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] mem [0:11];

    typedef struct packed {
        logic        start;
        logic        gv;
        logic [7:0]  gd;
        logic        dv;
        logic [7:0]  dout;
        logic        rd_en;
        logic [15:0] rd_addr;
        logic        wr_en;
        logic [15:0] wr_addr;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl [21];

    rgb_pixel_source #(.WIDTH(2), .HEIGHT(2), .AW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .dout       (dout),
        .dout_valid (dout_valid),
        .pause      (pause),
        .gray_valid (gray_valid),
        .gray_data  (gray_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source memory with one cycle of read latency
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= (rd_addr < 16'd12) ? mem[rd_addr[3:0]] : 8'hEE;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the edge, then leave time at the sample point
    task automatic step(input logic s, input logic p, input logic gv, input logic [7:0] gd);
        @(posedge clk);
        #2;
        start      = s;
        pause      = p;
        gray_valid = gv;
        gray_data  = gd;
        #2;
    endtask

    function automatic vec_t mk(input logic s, input logic gv, input logic [7:0] gd,
                                input logic dv, input logic [7:0] d, input logic re,
                                input logic [15:0] ra, input logic we, input logic [15:0] wa,
                                input logic b, input logic dn);
        vec_t v;
        v.start = s;  v.gv = gv;     v.gd = gd;
        v.dv = dv;    v.dout = d;    v.rd_en = re; v.rd_addr = ra;
        v.wr_en = we; v.wr_addr = wa; v.busy = b;  v.done = dn;
        return v;
    endfunction

    initial begin
        logic done_seen;
        int   pulses;

        for (int i = 0; i < 12; i++) mem[i] = 8'h10 + 8'(i);
        rd_data    = 8'h00;
        rst_n      = 1'b0;
        start      = 1'b0;
        pause      = 1'b0;
        gray_valid = 1'b1;
        gray_data  = 8'h55;

        // Reset state, with a result strobe held high to show it is ignored
        #12;
        chk("reset busy", busy, 0);
        chk("reset rd_en", rd_en, 0);
        chk("reset rd_addr", rd_addr, 0);
        chk("reset dout", dout, 0);
        chk("reset dout_valid", dout_valid, 0);
        chk("reset wr_en", wr_en, 0);
        chk("reset done", done, 0);
        gray_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Result strobes while idle produce no writes
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 8'h77);
            chk($sformatf("idle%0d wr_en", i), wr_en, 0);
            chk($sformatf("idle%0d busy", i), busy, 0);
        end

        // Full frame at full throughput, results written back after the stream drains
        tbl[0]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 16'd0,  0, 16'd0, 0, 0);
        tbl[1]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 16'd0,  0, 16'd0, 1, 0);
        tbl[2]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 16'd1,  0, 16'd0, 1, 0);
        tbl[3]  = mk(0, 0, 8'h00, 1, 8'h10, 1, 16'd2,  0, 16'd0, 1, 0);
        tbl[4]  = mk(0, 0, 8'h00, 1, 8'h11, 1, 16'd3,  0, 16'd0, 1, 0);
        tbl[5]  = mk(0, 0, 8'h00, 1, 8'h12, 1, 16'd4,  0, 16'd0, 1, 0);
        tbl[6]  = mk(0, 0, 8'h00, 1, 8'h13, 1, 16'd5,  0, 16'd0, 1, 0);
        tbl[7]  = mk(0, 0, 8'h00, 1, 8'h14, 1, 16'd6,  0, 16'd0, 1, 0);
        tbl[8]  = mk(0, 0, 8'h00, 1, 8'h15, 1, 16'd7,  0, 16'd0, 1, 0);
        tbl[9]  = mk(0, 0, 8'h00, 1, 8'h16, 1, 16'd8,  0, 16'd0, 1, 0);
        tbl[10] = mk(0, 0, 8'h00, 1, 8'h17, 1, 16'd9,  0, 16'd0, 1, 0);
        tbl[11] = mk(0, 0, 8'h00, 1, 8'h18, 1, 16'd10, 0, 16'd0, 1, 0);
        tbl[12] = mk(0, 0, 8'h00, 1, 8'h19, 1, 16'd11, 0, 16'd0, 1, 0);
        tbl[13] = mk(0, 0, 8'h00, 1, 8'h1A, 0, 16'd11, 0, 16'd0, 1, 0);
        tbl[14] = mk(0, 0, 8'h00, 1, 8'h1B, 0, 16'd11, 0, 16'd0, 1, 0);
        tbl[15] = mk(0, 1, 8'hA0, 0, 8'h00, 0, 16'd11, 1, 16'd0, 1, 0);
        tbl[16] = mk(0, 1, 8'hA1, 0, 8'h00, 0, 16'd11, 1, 16'd1, 1, 0);
        tbl[17] = mk(0, 1, 8'hA2, 0, 8'h00, 0, 16'd11, 1, 16'd2, 1, 0);
        tbl[18] = mk(0, 1, 8'hA3, 0, 8'h00, 0, 16'd11, 1, 16'd3, 1, 0);
        tbl[19] = mk(0, 0, 8'h00, 0, 8'h00, 0, 16'd11, 0, 16'd4, 1, 1);
        tbl[20] = mk(0, 0, 8'h00, 0, 8'h00, 0, 16'd11, 0, 16'd4, 0, 0);

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].start, 0, tbl[i].gv, tbl[i].gd);
            chk($sformatf("row%0d dout_valid", i), dout_valid, tbl[i].dv);
            if (tbl[i].dv) chk($sformatf("row%0d dout", i), dout, tbl[i].dout);
            chk($sformatf("row%0d rd_en", i), rd_en, tbl[i].rd_en);
            chk($sformatf("row%0d rd_addr", i), rd_addr, tbl[i].rd_addr);
            chk($sformatf("row%0d wr_en", i), wr_en, tbl[i].wr_en);
            chk($sformatf("row%0d wr_addr", i), wr_addr, tbl[i].wr_addr);
            if (tbl[i].wr_en) chk($sformatf("row%0d wr_data", i), wr_data, tbl[i].gd);
            chk($sformatf("row%0d busy", i), busy, tbl[i].busy);
            chk($sformatf("row%0d done", i), done, tbl[i].done);
        end

        // Consumer stall on 0x12, a stray start while busy, and early results
        step(1, 0, 0, 8'h00);
        for (int c = 1; c <= 4; c++) step(0, 0, 0, 8'h00);
        chk("stall pre dout", dout, 8'h11);
        for (int c = 5; c <= 7; c++) begin
            step((c == 6), 1, 0, 8'h00);
            chk($sformatf("stall c%0d dout", c), dout, 8'h12);
            chk($sformatf("stall c%0d dout_valid", c), dout_valid, 1);
            chk($sformatf("stall c%0d rd_en", c), rd_en, 0);
            chk($sformatf("stall c%0d rd_addr", c), rd_addr, 4);
        end
        step(0, 0, 0, 8'h00);
        chk("release dout", dout, 8'h12);
        chk("release rd_en", rd_en, 1);
        chk("release rd_addr", rd_addr, 4);
        for (int c = 9; c <= 12; c++) begin
            step(0, 0, 1, 8'hA0 + 8'(c - 9));
            chk($sformatf("early c%0d dout", c), dout, 8'h13 + 8'(c - 9));
            chk($sformatf("early c%0d wr_en", c), wr_en, 1);
            chk($sformatf("early c%0d wr_addr", c), wr_addr, 16'(c - 9));
        end
        for (int c = 13; c <= 17; c++) begin
            step(0, 0, 0, 8'h00);
            chk($sformatf("tail c%0d dout", c), dout, 8'h17 + 8'(c - 13));
            chk($sformatf("tail c%0d done", c), done, 0);
        end
        step(0, 0, 1, 8'hCC);
        chk("drain busy", busy, 1);
        chk("drain done", done, 0);
        chk("drain extra wr_en", wr_en, 0);
        step(0, 0, 0, 8'h00);
        chk("stall frame done", done, 1);
        step(0, 0, 0, 8'h00);
        chk("stall frame idle", busy, 0);

        // Reset after five accepted bytes abandons the frame
        step(1, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        step(0, 0, 1, 8'hB0);
        chk("pre-reset wr_addr", wr_addr, 0);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        chk("pre-reset dout", dout, 8'h14);
        @(posedge clk);
        #2;
        rst_n      = 1'b0;
        gray_valid = 1'b1;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset rd_en", rd_en, 0);
        chk("midreset rd_addr", rd_addr, 0);
        chk("midreset dout_valid", dout_valid, 0);
        chk("midreset dout", dout, 0);
        chk("midreset wr_en", wr_en, 0);
        chk("midreset done", done, 0);
        gray_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;

        step(1, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        chk("restart rd_en", rd_en, 1);
        chk("restart rd_addr", rd_addr, 0);
        step(0, 0, 0, 8'h00);
        step(0, 0, 1, 8'hC0);
        chk("restart dout", dout, 8'h10);
        chk("restart wr_en", wr_en, 1);
        chk("restart wr_addr", wr_addr, 0);

        done_seen = 1'b0;
        pulses    = 0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            step(0, 0, (pulses < 3), 8'hC1);
            if (wr_en) pulses++;
            if (done) done_seen = 1'b1;
        end
        chk("restart frame done", done_seen, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
